// File: rtl/esther_trig_pkg.sv
// Shared definitions for the trigger chain and its synthetic ADC stimulus source:
// widths, the stimulus FSM state encoding and the saturating sample adder.
package esther_trig_pkg;

   localparam int ADC_DATA_WIDTH = 16;
   localparam int WAIT_WIDTH     = 24;

   // Stimulus FSM state encoding; the register is a plain 3-bit vector so it can be probed directly.
   typedef logic [2:0] stim_state_t;
   localparam stim_state_t ST_IDLE    = 3'd0;
   localparam stim_state_t ST_LEAD    = 3'd1;
   localparam stim_state_t ST_PULSE_A = 3'd2;
   localparam stim_state_t ST_GAP_AB  = 3'd3;
   localparam stim_state_t ST_PULSE_B = 3'd4;
   localparam stim_state_t ST_GAP_BC  = 3'd5;
   localparam stim_state_t ST_PULSE_C = 3'd6;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {a[15], a} + {b[15], b};
      // The two top bits disagree only when the signed result left the 16-bit range.
      if (sum[16:15] == 2'b01) begin
         return 16'h7FFF;
      end else if (sum[16:15] == 2'b10) begin
         return 16'h8000;
      end else begin
         return sum[15:0];
      end
   endfunction

endpackage

// File: rtl/stim_chan_out.sv
// One ADC channel output register: picks pulse level or baseline and packs the
// sample twice into the two-samples-per-clock word.
module stim_chan_out #(
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pulse_sel,
   input  logic [DW-1:0]   level,
   input  logic [DW-1:0]   base,
   output logic [2*DW-1:0] data,
   output logic            enable,
   output logic            valid
);

   logic [2*DW-1:0] data_q, data_d;
   logic            enable_q, enable_d;
   logic            valid_q, valid_d;
   logic [DW-1:0]   sample;

   always_comb begin
      sample   = pulse_sel ? level : base;
      data_d   = {sample, sample};
      enable_d = 1'b1;
      valid_d  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q   <= '0;
         enable_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         data_q   <= data_d;
         enable_q <= enable_d;
         valid_q  <= valid_d;
      end
   end

   assign data   = data_q;
   assign enable = enable_q;
   assign valid  = valid_q;

endmodule

// File: rtl/pulse_stim_gen.sv
// Synthetic 4-channel ADC source: baseline plus three timed rectangular pulses on A, B, C.
// Output registers are loaded from the next state, so channel data lines up with state_q.
module pulse_stim_gen #(
   parameter int ADC_DATA_WIDTH = esther_trig_pkg::ADC_DATA_WIDTH,
   parameter int WAIT_WIDTH     = esther_trig_pkg::WAIT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [ADC_DATA_WIDTH-1:0]   baseline,
   input  logic [ADC_DATA_WIDTH-1:0]   amplitude,
   input  logic [WAIT_WIDTH-1:0]       pulse_width,
   input  logic [WAIT_WIDTH-1:0]       lead_delay,
   input  logic [WAIT_WIDTH-1:0]       delay_ab,
   input  logic [WAIT_WIDTH-1:0]       delay_bc,
   output logic [2*ADC_DATA_WIDTH-1:0] adc_data_a,
   output logic [2*ADC_DATA_WIDTH-1:0] adc_data_b,
   output logic [2*ADC_DATA_WIDTH-1:0] adc_data_c,
   output logic [2*ADC_DATA_WIDTH-1:0] adc_data_d,
   output logic                        adc_enable_a,
   output logic                        adc_enable_b,
   output logic                        adc_enable_c,
   output logic                        adc_enable_d,
   output logic                        adc_valid_a,
   output logic                        adc_valid_b,
   output logic                        adc_valid_c,
   output logic                        adc_valid_d,
   output logic                        busy,
   output logic                        done,
   output logic [2:0]                  dbg_state
);

   import esther_trig_pkg::*;

   localparam logic [WAIT_WIDTH-1:0] CNT_ONE = WAIT_WIDTH'(1);

   stim_state_t                 state_q, state_d;
   logic [WAIT_WIDTH-1:0]       cnt_q, cnt_d;
   logic [WAIT_WIDTH-1:0]       width_q, width_d;
   logic [WAIT_WIDTH-1:0]       gap_ab_q, gap_ab_d;
   logic [WAIT_WIDTH-1:0]       gap_bc_q, gap_bc_d;
   logic [ADC_DATA_WIDTH-1:0]   base_q, base_d;
   logic [ADC_DATA_WIDTH-1:0]   level_q, level_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic [WAIT_WIDTH-1:0]       width_in;
   logic [ADC_DATA_WIDTH-1:0]   chan_base, chan_level;

   always_comb begin
      width_in = (pulse_width == '0) ? CNT_ONE : pulse_width;
      state_d  = state_q;
      cnt_d    = cnt_q;
      width_d  = width_q;
      gap_ab_d = gap_ab_q;
      gap_bc_d = gap_bc_q;
      base_d   = base_q;
      level_d  = level_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               width_d  = width_in;
               // A gap is the part of a delay not covered by the preceding pulse.
               gap_ab_d = (delay_ab > width_in) ? delay_ab - width_in : '0;
               gap_bc_d = (delay_bc > width_in) ? delay_bc - width_in : '0;
               base_d   = baseline;
               level_d  = sat_add16(baseline, amplitude);
               if (lead_delay == '0) begin
                  state_d = ST_PULSE_A;
                  cnt_d   = width_in - CNT_ONE;
               end else begin
                  state_d = ST_LEAD;
                  cnt_d   = lead_delay - CNT_ONE;
               end
            end
         end
         ST_LEAD: begin
            if (cnt_q == '0) begin
               state_d = ST_PULSE_A;
               cnt_d   = width_q - CNT_ONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_PULSE_A: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (gap_ab_q == '0) begin
               state_d = ST_PULSE_B;
               cnt_d   = width_q - CNT_ONE;
            end else begin
               state_d = ST_GAP_AB;
               cnt_d   = gap_ab_q - CNT_ONE;
            end
         end
         ST_GAP_AB: begin
            if (cnt_q == '0) begin
               state_d = ST_PULSE_B;
               cnt_d   = width_q - CNT_ONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_PULSE_B: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (gap_bc_q == '0) begin
               state_d = ST_PULSE_C;
               cnt_d   = width_q - CNT_ONE;
            end else begin
               state_d = ST_GAP_BC;
               cnt_d   = gap_bc_q - CNT_ONE;
            end
         end
         ST_GAP_BC: begin
            if (cnt_q == '0) begin
               state_d = ST_PULSE_C;
               cnt_d   = width_q - CNT_ONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_PULSE_C: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      // While idle the channels follow the live inputs; this also covers the accepting cycle.
      chan_base  = (state_q == ST_IDLE) ? baseline : base_q;
      chan_level = (state_q == ST_IDLE) ? sat_add16(baseline, amplitude) : level_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         width_q  <= '0;
         gap_ab_q <= '0;
         gap_bc_q <= '0;
         base_q   <= '0;
         level_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         width_q  <= width_d;
         gap_ab_q <= gap_ab_d;
         gap_bc_q <= gap_bc_d;
         base_q   <= base_d;
         level_q  <= level_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   stim_chan_out #(.DW(ADC_DATA_WIDTH)) u_chan_a (
      .clk(clk), .rst(rst), .pulse_sel(state_d == ST_PULSE_A), .level(chan_level),
      .base(chan_base), .data(adc_data_a), .enable(adc_enable_a), .valid(adc_valid_a)
   );
   stim_chan_out #(.DW(ADC_DATA_WIDTH)) u_chan_b (
      .clk(clk), .rst(rst), .pulse_sel(state_d == ST_PULSE_B), .level(chan_level),
      .base(chan_base), .data(adc_data_b), .enable(adc_enable_b), .valid(adc_valid_b)
   );
   stim_chan_out #(.DW(ADC_DATA_WIDTH)) u_chan_c (
      .clk(clk), .rst(rst), .pulse_sel(state_d == ST_PULSE_C), .level(chan_level),
      .base(chan_base), .data(adc_data_c), .enable(adc_enable_c), .valid(adc_valid_c)
   );
   stim_chan_out #(.DW(ADC_DATA_WIDTH)) u_chan_d (
      .clk(clk), .rst(rst), .pulse_sel(1'b0), .level(chan_level),
      .base(chan_base), .data(adc_data_d), .enable(adc_enable_d), .valid(adc_valid_d)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_stim_gen.sv
// Directed bench for pulse_stim_gen: reset, nominal timing, boundary delays,
// saturation, ignored restart with input capture, and mid-run abort.
module tb_pulse_stim_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] baseline, amplitude;
   logic [23:0] pulse_width, lead_delay, delay_ab, delay_bc;
   logic [31:0] adc_data_a, adc_data_b, adc_data_c, adc_data_d;
   logic        adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d;
   logic        adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d;
   logic        busy, done;
   logic [2:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   always #4 clk = ~clk;

   pulse_stim_gen dut (
      .clk(clk), .rst(rst), .start(start),
      .baseline(baseline), .amplitude(amplitude), .pulse_width(pulse_width),
      .lead_delay(lead_delay), .delay_ab(delay_ab), .delay_bc(delay_bc),
      .adc_data_a(adc_data_a), .adc_data_b(adc_data_b),
      .adc_data_c(adc_data_c), .adc_data_d(adc_data_d),
      .adc_enable_a(adc_enable_a), .adc_enable_b(adc_enable_b),
      .adc_enable_c(adc_enable_c), .adc_enable_d(adc_enable_d),
      .adc_valid_a(adc_valid_a), .adc_valid_b(adc_valid_b),
      .adc_valid_c(adc_valid_c), .adc_valid_d(adc_valid_d),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_level(input logic [15:0] b, input logic [15:0] a);
      int s;
      s = int'($signed(b)) + int'($signed(a));
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return 16'(s);
   endfunction

   function automatic logic [31:0] en_vec();
      return {24'd0, adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d,
              adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d};
   endfunction

   task automatic check_reset_zero(input string tag);
      check({tag, " data_a"}, adc_data_a, 32'h0);
      check({tag, " data_b"}, adc_data_b, 32'h0);
      check({tag, " data_c"}, adc_data_c, 32'h0);
      check({tag, " data_d"}, adc_data_d, 32'h0);
      check({tag, " en_valid"}, en_vec(), 32'h0);
      check({tag, " busy"}, {31'd0, busy}, 32'h0);
      check({tag, " done"}, {31'd0, done}, 32'h0);
      check({tag, " state"}, {29'd0, dbg_state}, 32'h0);
   endtask

   // Starts a run at a negedge and checks every cycle k after acceptance against a timing model.
   task automatic run_seq(input string tag, input int lead, input int w, input int dab,
                          input int dbc, input logic [15:0] base, input logic [15:0] amp,
                          input int restart_k, input int abort_k);
      int          w_eff, ea, eb, ec, e_end, n;
      logic [31:0] pw, bw;
      logic [15:0] lvl;
      w_eff = (w == 0) ? 1 : w;
      ea    = 1 + lead;
      eb    = ea + ((dab > w_eff) ? dab : w_eff);
      ec    = eb + ((dbc > w_eff) ? dbc : w_eff);
      e_end = ec + w_eff;
      n     = e_end + 3;
      lvl   = model_level(base, amp);
      pw    = {lvl, lvl};
      bw    = {base, base};
      baseline    = base;
      amplitude   = amp;
      pulse_width = 24'(w);
      lead_delay  = 24'(lead);
      delay_ab    = 24'(dab);
      delay_bc    = 24'(dbc);
      start       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= n; k++) begin
         check($sformatf("%s a k=%0d", tag, k), adc_data_a,
               (k >= ea && k < ea + w_eff) ? pw : bw);
         check($sformatf("%s b k=%0d", tag, k), adc_data_b,
               (k >= eb && k < eb + w_eff) ? pw : bw);
         check($sformatf("%s c k=%0d", tag, k), adc_data_c,
               (k >= ec && k < ec + w_eff) ? pw : bw);
         check($sformatf("%s d k=%0d", tag, k), adc_data_d, bw);
         check($sformatf("%s busy k=%0d", tag, k), {31'd0, busy}, {31'd0, k < e_end});
         check($sformatf("%s done k=%0d", tag, k), {31'd0, done}, {31'd0, k == e_end});
         check($sformatf("%s en k=%0d", tag, k), en_vec(), 32'h0000_00FF);
         if (k == abort_k) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            check_reset_zero({tag, " abort"});
            return;
         end
         start = (k == restart_k);
         // Captured inputs must not influence the running sequence.
         if (k == 2) begin
            amplitude   = ~amp;
            pulse_width = 24'd7;
            delay_ab    = 24'd3;
            delay_bc    = 24'd200;
            lead_delay  = 24'd9;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      baseline    = 16'h0010;
      amplitude   = 16'h0000;
      pulse_width = '0;
      lead_delay  = '0;
      delay_ab    = '0;
      delay_bc    = '0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_reset_zero($sformatf("reset c%0d", i));
      end
      rst = 1'b0;
      @(negedge clk);
      check("post_reset en", en_vec(), 32'h0000_00FF);
      check("post_reset data_a", adc_data_a, 32'h0010_0010);
      check("post_reset data_d", adc_data_d, 32'h0010_0010);
      check("post_reset busy", {31'd0, busy}, 32'h0);
      check("post_reset done", {31'd0, done}, 32'h0);

      run_seq("nominal", 10, 4, 100, 50, 16'h0000, 16'h1000, 0, 0);
      run_seq("boundary", 0, 0, 0, 1, 16'h0123, 16'h0200, 0, 0);
      run_seq("sat_hi", 2, 3, 5, 3, 16'h7000, 16'h2000, 0, 0);
      run_seq("sat_lo", 0, 2, 2, 6, 16'h9000, 16'hE000, 0, 0);
      run_seq("restart", 10, 4, 100, 50, 16'h0040, 16'h1000, 50, 0);
      run_seq("abort", 10, 4, 100, 50, 16'h0000, 16'h1000, 0, 112);

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("after_abort en %0d", i), en_vec(), 32'h0000_00FF);
         check($sformatf("after_abort busy %0d", i), {31'd0, busy}, 32'h0);
         check($sformatf("after_abort done %0d", i), {31'd0, done}, 32'h0);
      end
      run_seq("fresh", 10, 4, 100, 50, 16'h0000, 16'h1000, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
